usb_line_filter: RTL and testbench

Parametrised multi-channel input filter and change detector for double-rate sampled line inputs. It sits between the vendor I/O primitives, which supply two samples per clock per pin, and the USB RX bit recovery logic. Each channel passes through an optional synchroniser, then a run-length glitch filter with configurable length. Outputs are the filtered levels, per-channel and aggregate change strobes, and a saturating idle counter measuring clocks since the last accepted transition.

---
 rtl/usb_line_filter.sv | 118 +++++++++++
 tb/tb_usb_line_filter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_line_filter.sv
// Multi-channel run-length glitch filter for double-rate sampled line inputs.
// Optional input synchroniser, per-channel change strobes and a saturating idle counter.
module usb_line_filter #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned FILT_LEN    = 2,
  parameter int unsigned SYNC_STAGES = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  rx_in_0,
  input  logic [N_CH-1:0]  rx_in_1,
  output logic [N_CH-1:0]  rx_val,
  output logic [N_CH-1:0]  rx_chg_ch,
  output logic             rx_chg,
  output logic [CNT_W-1:0] idle_cnt,
  output logic             idle_sat
);

  localparam int unsigned RW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(FILT_LEN - 1);

  logic [N_CH-1:0]  smp_0;
  logic [N_CH-1:0]  smp_1;
  logic [RW-1:0]    r_q   [N_CH];
  logic [RW+1:0]    st    [N_CH];
  logic [N_CH-1:0]  val_n;
  logic [N_CH-1:0]  flip_n;
  logic [CNT_W-1:0] idle_next;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign smp_0 = rx_in_0;
    assign smp_1 = rx_in_1;
  end else begin : g_sync
    logic [N_CH-1:0] pipe_0 [SYNC_STAGES];
    logic [N_CH-1:0] pipe_1 [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
          pipe_0[k] <= '0;
          pipe_1[k] <= '0;
        end
      end else begin
        pipe_0[0] <= rx_in_0;
        pipe_1[0] <= rx_in_1;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
          pipe_0[k] <= pipe_0[k-1];
          pipe_1[k] <= pipe_1[k-1];
        end
      end
    end

    assign smp_0 = pipe_0[SYNC_STAGES-1];
    assign smp_1 = pipe_1[SYNC_STAGES-1];
  end

  // State word is {flip_seen, v, r}; flip_seen accumulates across both samples.
  function automatic logic [RW+1:0] step(input logic [RW+1:0] cur, input logic s);
    logic          f;
    logic          v;
    logic [RW-1:0] r;
    {f, v, r} = cur;
    if (s == v) begin
      r = '0;
    end else if (r == R_LAST) begin
      v = s;
      r = '0;
      f = 1'b1;
    end else begin
      r = r + 1'b1;
    end
    return {f, v, r};
  endfunction

  always_comb begin
    val_n  = '0;
    flip_n = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      st[i]     = step(step({1'b0, rx_val[i], r_q[i]}, smp_0[i]), smp_1[i]);
      val_n[i]  = st[i][RW];
      flip_n[i] = st[i][RW+1];
    end
  end

  // Counter clears off the registered strobe, so it reads 0 one cycle after rx_chg.
  always_comb begin
    idle_next = idle_cnt;
    if (rx_chg) begin
      idle_next = '0;
    end else if (!(&idle_cnt)) begin
      idle_next = idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_val    <= '0;
      rx_chg_ch <= '0;
      rx_chg    <= 1'b0;
      idle_cnt  <= '0;
      idle_sat  <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      rx_val    <= val_n;
      rx_chg_ch <= flip_n;
      rx_chg    <= |flip_n;
      idle_cnt  <= idle_next;
      idle_sat  <= &idle_next;
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_q[i] <= st[i][RW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_usb_line_filter.sv
// Bench for usb_line_filter: four parameter variants on shared stimulus,
// checked every cycle against a sample-history model plus literal expectations.
module tb_usb_line_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] rx_in_0 = '0;
  logic [1:0] rx_in_1 = '0;

  always #5 clk = ~clk;

  // u0 default, u1 FILT_LEN=1, u2 CNT_W=4, u3 SYNC_STAGES=2
  logic [1:0] val0, val1, val2, val3;
  logic [1:0] cch0, cch1, cch2, cch3;
  logic       chg0, chg1, chg2, chg3;
  logic [7:0] idl0, idl1, idl3;
  logic [3:0] idl2;
  logic       sat0, sat1, sat2, sat3;

  usb_line_filter #(.N_CH(2), .FILT_LEN(2), .SYNC_STAGES(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .rx_in_0(rx_in_0), .rx_in_1(rx_in_1),
    .rx_val(val0), .rx_chg_ch(cch0), .rx_chg(chg0), .idle_cnt(idl0), .idle_sat(sat0));
  usb_line_filter #(.N_CH(2), .FILT_LEN(1), .SYNC_STAGES(0), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .rx_in_0(rx_in_0), .rx_in_1(rx_in_1),
    .rx_val(val1), .rx_chg_ch(cch1), .rx_chg(chg1), .idle_cnt(idl1), .idle_sat(sat1));
  usb_line_filter #(.N_CH(2), .FILT_LEN(2), .SYNC_STAGES(0), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .rx_in_0(rx_in_0), .rx_in_1(rx_in_1),
    .rx_val(val2), .rx_chg_ch(cch2), .rx_chg(chg2), .idle_cnt(idl2), .idle_sat(sat2));
  usb_line_filter #(.N_CH(2), .FILT_LEN(2), .SYNC_STAGES(2), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .rx_in_0(rx_in_0), .rx_in_1(rx_in_1),
    .rx_val(val3), .rx_chg_ch(cch3), .rx_chg(chg3), .idle_cnt(idl3), .idle_sat(sat3));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Model: samples since the last accepted transition are kept per channel;
  // a transition is accepted once the newest FILT_LEN of them all oppose the level.
  int cfg_f [4] = '{2, 1, 2, 2};
  int cfg_s [4] = '{0, 0, 0, 2};
  int cfg_w [4] = '{8, 8, 4, 8};

  logic [1:0] m_val    [4];
  logic [1:0] m_chg_ch [4];
  logic       m_chg    [4];
  int         m_idle   [4];
  bit         hist     [8][$];
  logic [3:0] dq       [4][$];
  bit         model_ok = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [3:0] p;
    logic       s;
    bit         ok;
    logic [1:0] flips;
    int         h;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_val[i]    = '0;
        m_chg_ch[i] = '0;
        m_chg[i]    = 1'b0;
        m_idle[i]   = 0;
        dq[i].delete();
        for (int k = 0; k < cfg_s[i]; k++) dq[i].push_back(4'b0000);
        hist[2*i].delete();
        hist[2*i+1].delete();
      end
      model_ok = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        dq[i].push_back({rx_in_1, rx_in_0});
        p = dq[i].pop_front();
        if (m_chg[i]) m_idle[i] = 0;
        else if (m_idle[i] < (1 << cfg_w[i]) - 1) m_idle[i] = m_idle[i] + 1;
        flips = '0;
        for (int c = 0; c < 2; c++) begin
          h = 2*i + c;
          for (int k = 0; k < 2; k++) begin
            s = (k == 1) ? p[2+c] : p[c];
            hist[h].push_back(s);
            if (hist[h].size() > 8) void'(hist[h].pop_front());
            ok = (hist[h].size() >= cfg_f[i]);
            for (int j = 0; j < cfg_f[i]; j++)
              if (ok && hist[h][hist[h].size()-1-j] == m_val[i][c]) ok = 1'b0;
            if (ok) begin
              m_val[i][c] = s;
              flips[c] = 1'b1;
              hist[h].delete();
            end
          end
        end
        m_chg_ch[i] = flips;
        m_chg[i]    = |flips;
      end
    end
  end

  task automatic cmp(input int i, input logic [1:0] v, input logic [1:0] cc,
                     input logic c, input int idl, input logic sat);
    check($sformatf("u%0d_rx_val", i),    int'(v),   int'(m_val[i]));
    check($sformatf("u%0d_rx_chg_ch", i), int'(cc),  int'(m_chg_ch[i]));
    check($sformatf("u%0d_rx_chg", i),    int'(c),   int'(m_chg[i]));
    check($sformatf("u%0d_idle_cnt", i),  idl,       m_idle[i]);
    check($sformatf("u%0d_idle_sat", i),  int'(sat), int'(m_idle[i] == (1 << cfg_w[i]) - 1));
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      cmp(0, val0, cch0, chg0, int'(idl0), sat0);
      cmp(1, val1, cch1, chg1, int'(idl1), sat1);
      cmp(2, val2, cch2, chg2, int'(idl2), sat2);
      cmp(3, val3, cch3, chg3, int'(idl3), sat3);
    end
  end

  task automatic drive(input logic [1:0] a0, input logic [1:0] a1);
    rx_in_0 = a0;
    rx_in_1 = a1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_val",  int'(val0), 0);
    check("rst_chg",  int'(chg0), 0);
    check("rst_idle", int'(idl0), 0);
    check("rst_sat",  int'(sat0), 0);
    rst = 1'b0;

    // basic transition on ch0
    drive(2'b01, 2'b01);
    check("t1_val", int'(val0), 1);
    check("t1_chg_ch", int'(cch0), 1);
    check("t1_chg", int'(chg0), 1);
    drive(2'b01, 2'b01);
    check("t1_pulse_end", int'(cch0), 0);
    check("t1_idle0", int'(idl0), 0);
    drive(2'b01, 2'b01);
    check("t1_idle1", int'(idl0), 1);

    // glitch on ch1
    drive(2'b01, 2'b11);
    check("t2_val_a", int'(val0), 1);
    check("t2_chg_a", int'(chg0), 0);
    drive(2'b01, 2'b01);
    check("t2_val_b", int'(val0), 1);
    check("t2_chg_b", int'(chg0), 0);

    // run across clock boundary
    drive(2'b00, 2'b00);
    check("t3_back0", int'(val0), 0);
    drive(2'b00, 2'b00);
    drive(2'b00, 2'b01);
    check("t3_half_val", int'(val0), 0);
    check("t3_half_chg", int'(chg0), 0);
    drive(2'b01, 2'b00);
    check("t3_val", int'(val0), 1);
    check("t3_chg_ch", int'(cch0), 1);
    drive(2'b01, 2'b01);
    check("t3_hold_val", int'(val0), 1);
    check("t3_hold_chg", int'(cch0), 0);

    // double flip with FILT_LEN=1
    drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);
    drive(2'b01, 2'b00);
    check("t4_val", int'(val1), 0);
    check("t4_chg_ch", int'(cch1), 1);
    check("t4_u0_chg_ch", int'(cch0), 0);

    // idle saturation with CNT_W=4
    repeat (20) drive(2'b00, 2'b00);
    check("t5_idle_sat_cnt", int'(idl2), 15);
    check("t5_idle_sat", int'(sat2), 1);
    drive(2'b01, 2'b01);
    check("t5_chg", int'(chg2), 1);
    check("t5_idle_held", int'(idl2), 15);
    drive(2'b01, 2'b01);
    check("t5_idle_clr", int'(idl2), 0);
    check("t5_sat_clr", int'(sat2), 0);

    // reset mid-run
    drive(2'b00, 2'b00);
    drive(2'b00, 2'b00);
    drive(2'b00, 2'b01);
    rst = 1'b1;
    rx_in_0 = '0;
    rx_in_1 = '0;
    #1;
    check("t6_async_val", int'(val0), 0);
    check("t6_async_idle", int'(idl0), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(2'b01, 2'b00);
    check("t6_noflip_val", int'(val0), 0);
    check("t6_noflip_chg", int'(chg0), 0);

    // sync latency
    drive(2'b01, 2'b01);
    check("t6_sync_1", int'(val3), 0);
    drive(2'b01, 2'b01);
    check("t6_sync_2", int'(val3), 0);
    drive(2'b01, 2'b01);
    check("t6_sync_3", int'(val3), 1);
    check("t6_sync_chg", int'(cch3), 1);

    repeat (4) drive(2'b10, 2'b10);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
